// File: rtl/acc_alu_pkg.sv
// acc_alu_pkg: shared opcodes, FSM states
// and default width for the accumulator ALU.
package acc_alu_pkg;

    localparam int DEF_WIDTH = 7;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_RLC  = 4'd7;
    localparam logic [3:0] OP_RRC  = 4'd8;
    localparam logic [3:0] OP_CLC  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/acc_alu_mul_iter.sv
// acc_alu_mul_iter: shift-add multiplier,
// one partial-product step per enabled cycle.
module acc_alu_mul_iter
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod_nxt
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    assign busy = (cnt_q != '0);
    // done: the coming enabled edge is the last step
    assign done = (cnt_q == CW'(1));

    // Partial product after the current step
    always_comb begin
        prod_nxt = prod_q;
        if (mplier_q[0])
            prod_nxt = prod_q + mcand_q;
    end

    // Operand latch on start, then shift-add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (ena) begin
            if (start) begin
                mcand_q  <= {{WIDTH{1'b0}}, mcand};
                mplier_q <= mplier;
                prod_q   <= '0;
                cnt_q    <= CW'(WIDTH);
            end else if (busy) begin
                prod_q   <= prod_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/acc_alu_seq.sv
// acc_alu_seq: accumulator ALU with flags,
// valid/ready handshake and optional iterative MUL.
module acc_alu_seq
    import acc_alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] operand,
    input  logic [3:0]       opcode,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] accu,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             done
);

    localparam int M = WIDTH - 1;

    state_t state_q, state_d;

    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic               mul_fin;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0] acc_d;
    logic             c_d, z_d, v_d;
    logic             wr, done_d;
    logic [WIDTH:0]   sum, dif;

    assign accept    = ena & op_valid & op_ready;
    assign is_mul    = MUL_EN && (opcode == OP_MUL);
    assign mul_start = accept & is_mul;
    assign mul_fin   = ena & mul_busy & mul_done;

    generate
        if (MUL_EN) begin : g_mul
            acc_alu_mul_iter #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk      (clk),
                .rst_n    (rst_n),
                .ena      (ena),
                .start    (mul_start),
                .mcand    (accu),
                .mplier   (operand),
                .busy     (mul_busy),
                .done     (mul_done),
                .prod_nxt (mul_prod)
            );
        end else begin : g_nomul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else if (ena)
            state_q <= state_d;
    end

    // Next state and ready
    always_comb begin
        state_d  = state_q;
        op_ready = (state_q == ST_IDLE);
        unique case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_fin)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Opcode decode and flag rules
    always_comb begin
        sum = {1'b0, accu} + {1'b0, operand}
            + {{WIDTH{1'b0}}, carry};
        dif = {1'b0, accu} - {1'b0, operand};
        acc_d  = accu;
        c_d    = carry;
        v_d    = ovf;
        wr     = 1'b0;
        done_d = mul_fin;
        if (accept && !is_mul) begin
            done_d = 1'b1;
            case (opcode)
                OP_LOAD: begin
                    acc_d = operand;
                    v_d   = 1'b0;
                    wr    = 1'b1;
                end
                OP_ADC: begin
                    {c_d, acc_d} = sum;
                    v_d = (accu[M] == operand[M])
                        && (sum[M] != accu[M]);
                    wr  = 1'b1;
                end
                OP_SUB: begin
                    {c_d, acc_d} = dif;
                    v_d = (accu[M] != operand[M])
                        && (dif[M] != accu[M]);
                    wr  = 1'b1;
                end
                OP_AND: begin
                    acc_d = accu & operand;
                    v_d   = 1'b0;
                    wr    = 1'b1;
                end
                OP_OR: begin
                    acc_d = accu | operand;
                    v_d   = 1'b0;
                    wr    = 1'b1;
                end
                OP_XOR: begin
                    acc_d = accu ^ operand;
                    v_d   = 1'b0;
                    wr    = 1'b1;
                end
                OP_RLC: begin
                    {c_d, acc_d} = {accu, carry};
                    wr = 1'b1;
                end
                OP_RRC: begin
                    {acc_d, c_d} = {carry, accu};
                    wr = 1'b1;
                end
                OP_CLC: c_d = 1'b0;
                default: ;
            endcase
        end
        if (mul_fin) begin
            acc_d = mul_prod[WIDTH-1:0];
            c_d   = |mul_prod[2*WIDTH-1:WIDTH];
            v_d   = 1'b0;
            wr    = 1'b1;
        end
        z_d = wr ? (acc_d == '0) : zero;
    end

    // Architectural state; ena low freezes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accu  <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else if (ena) begin
            accu  <= acc_d;
            carry <= c_d;
            zero  <= z_d;
            ovf   <= v_d;
            done  <= done_d;
        end else begin
            done  <= 1'b0;
        end
    end

endmodule
